// File: rtl/mesh_pkg.sv
// Shared definitions for the mesh egress terminal: packet header layout,
// field offsets (measured from the packet MSB) and the egress FSM states.
package mesh_pkg;

  localparam int unsigned NXT_JMP_W = 8;
  localparam int unsigned ROW_W     = 4;
  localparam int unsigned COL_W     = 4;
  localparam int unsigned MODE_W    = 1;
  localparam int unsigned HDR_W     = NXT_JMP_W + ROW_W + COL_W + MODE_W;

  // Bit distance of each header field's MSB below the packet MSB.
  localparam int unsigned NXT_JMP_OFS = 0;
  localparam int unsigned DST_ROW_OFS = NXT_JMP_OFS + NXT_JMP_W;
  localparam int unsigned DST_COL_OFS = DST_ROW_OFS + ROW_W;
  localparam int unsigned MODE_OFS    = DST_COL_OFS + COL_W;

  // Header occupying the top HDR_W bits of every packet; payload follows.
  typedef struct packed {
    logic [NXT_JMP_W-1:0] nxt_jmp;
    logic [ROW_W-1:0]     dst_row;
    logic [COL_W-1:0]     dst_col;
    logic [MODE_W-1:0]    mode;
  } mesh_hdr_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } egress_state_t;

endpackage

// File: rtl/egress_fifo.sv
// Show-ahead receive FIFO for the egress terminal. Depth need not be a power
// of two; pointers wrap explicitly at fifo_depth.
// Ports: clk, reset (async, active-low), wr_en/wr_data (push), rd_en (pop head),
//        rd_valid (non-empty), rd_data (head entry, 0 when empty), count.
module egress_fifo #(
  parameter int unsigned pckg_sz    = 40,
  parameter int unsigned fifo_depth = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              wr_en,
  input  logic [pckg_sz-1:0]                wr_data,
  input  logic                              rd_en,
  output logic                              rd_valid,
  output logic [pckg_sz-1:0]                rd_data,
  output logic [$clog2(fifo_depth+1)-1:0]   count
);

  localparam int unsigned CNT_W = $clog2(fifo_depth + 1);
  localparam int unsigned PTR_W = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;

  logic [pckg_sz-1:0] mem [fifo_depth];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(fifo_depth - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage carries no reset; the output mux hides stale entries.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_valid = (count != '0);
  assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/mesh_egress_port.sv
// Mesh egress terminal: pops packets from the mesh output port, keeps those
// addressed to this (ROW, COL) in a local FIFO for the host, drops the rest.
// Ports: clk, reset (async, active-low); mesh side pndng/data_out/pop/enable;
//        host side rx_valid/rx_data/rx_ready; stats pkt_cnt, misroute_cnt,
//        misroute (one-cycle pulse per dropped packet).
module mesh_egress_port
  import mesh_pkg::*;
#(
  parameter int unsigned     pckg_sz    = 40,
  parameter int unsigned     fifo_depth = 4,
  parameter logic [ROW_W-1:0] ROW       = '0,
  parameter logic [COL_W-1:0] COL       = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pndng,
  input  logic [pckg_sz-1:0] data_out,
  output logic               pop,
  input  logic               enable,
  output logic               rx_valid,
  output logic [pckg_sz-1:0] rx_data,
  input  logic               rx_ready,
  output logic [15:0]        pkt_cnt,
  output logic [15:0]        misroute_cnt,
  output logic               misroute
);

  localparam int unsigned CNT_W = $clog2(fifo_depth + 1);

  egress_state_t    state;
  egress_state_t    state_nxt;
  logic [CNT_W-1:0] count;
  logic             fifo_full;
  logic             rd_en;
  logic             wr_en;
  logic             dst_match;

  assign dst_match = (data_out[pckg_sz-1-DST_ROW_OFS -: ROW_W] == ROW) &&
                     (data_out[pckg_sz-1-DST_COL_OFS -: COL_W] == COL);
  assign fifo_full = (count == CNT_W'(fifo_depth));
  assign rd_en     = rx_valid && rx_ready;
  assign wr_en     = pop && dst_match;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state and mesh pop; a full FIFO may still pop when the host reads
  // on the same edge.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        pop = pndng && (!fifo_full || rd_en);
        if (!enable) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (enable)         state_nxt = ST_ACTIVE;
        else if (!rx_valid) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (!reset) pop = 1'b0;
  end

  // Accepted count wraps; dropped count saturates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_cnt      <= '0;
      misroute_cnt <= '0;
      misroute     <= 1'b0;
    end else begin
      misroute <= pop && !dst_match;
      if (wr_en) pkt_cnt <= pkt_cnt + 16'd1;
      if (pop && !dst_match && (misroute_cnt != 16'hFFFF))
        misroute_cnt <= misroute_cnt + 16'd1;
    end
  end

  egress_fifo #(
    .pckg_sz    (pckg_sz),
    .fifo_depth (fifo_depth)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (data_out),
    .rd_en    (rd_en),
    .rd_valid (rx_valid),
    .rd_data  (rx_data),
    .count    (count)
  );

endmodule

// File: tb/tb_mesh_egress_port.sv
module tb_mesh_egress_port;
  import mesh_pkg::*;

  localparam int unsigned PW    = 40;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PL_W  = PW - HDR_W;
  localparam logic [3:0]  MY_ROW = 4'd1;
  localparam logic [3:0]  MY_COL = 4'd2;

  localparam int M_IDLE = 0, M_ACTIVE = 1, M_DRAIN = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          pndng;
  logic [PW-1:0] data_out;
  logic          pop;
  logic          enable;
  logic          rx_valid;
  logic [PW-1:0] rx_data;
  logic          rx_ready;
  logic [15:0]   pkt_cnt;
  logic [15:0]   misroute_cnt;
  logic          misroute;

  mesh_egress_port #(
    .pckg_sz(PW), .fifo_depth(DEPTH), .ROW(MY_ROW), .COL(MY_COL)
  ) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .data_out(data_out), .pop(pop),
    .enable(enable), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .pkt_cnt(pkt_cnt), .misroute_cnt(misroute_cnt), .misroute(misroute)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Mesh source (pending packets) and reference model state.
  logic [PW-1:0] src_q[$];
  logic [PW-1:0] exp_q[$];
  int            m_mode = M_IDLE;
  int            m_occ = 0;
  logic [15:0]   m_pkt = '0;
  logic [15:0]   m_mis = '0;
  logic          m_pulse = 1'b0;
  bit            popped = 1'b0;
  int            n_pops = 0;
  int            n_mis_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] mk(input logic [3:0] r, input logic [3:0] c,
                                       input logic [PL_W-1:0] pl);
    mesh_hdr_t h;
    h.nxt_jmp = 8'($urandom);
    h.dst_row = r;
    h.dst_col = c;
    h.mode    = 1'($urandom);
    return {h, pl};
  endfunction

  function automatic bit is_mine(input logic [PW-1:0] p);
    mesh_hdr_t h;
    h = p[PW-1 -: HDR_W];
    return (h.dst_row == MY_ROW) && (h.dst_col == MY_COL);
  endfunction

  task automatic drive_src();
    pndng    = (src_q.size() != 0);
    data_out = pndng ? src_q[0] : '0;
  endtask

  task automatic push(input logic [PW-1:0] p);
    src_q.push_back(p);
    drive_src();
  endtask

  // Advance one cycle; inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (popped) begin
      void'(src_q.pop_front());
      popped = 1'b0;
    end
    drive_src();
  endtask

  task automatic wait_rx_valid(input string name, input int budget);
    int n = 0;
    while (!rx_valid && n < budget) begin step(); n++; end
    check(name, 64'(rx_valid), 64'd1);
  endtask

  task automatic wait_rx_empty(input string name, input int budget);
    int n = 0;
    while (rx_valid && n < budget) begin step(); n++; end
    check(name, 64'(rx_valid), 64'd0);
  endtask

  // Monitor: mid-cycle, predict this edge's behaviour and compare.
  always @(negedge clk) begin
    int occ_now;
    bit m_pop;
    if (!reset) begin
      check("rst_pop", 64'(pop), 64'd0);
      check("rst_rx_valid", 64'(rx_valid), 64'd0);
      check("rst_rx_data", 64'(rx_data), 64'd0);
      check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
      check("rst_misroute_cnt", 64'(misroute_cnt), 64'd0);
      check("rst_misroute", 64'(misroute), 64'd0);
      m_mode = M_IDLE; m_occ = 0; exp_q.delete();
      m_pkt = '0; m_mis = '0; m_pulse = 1'b0;
    end else begin
      occ_now = m_occ;
      m_pop = (m_mode == M_ACTIVE) && (src_q.size() != 0) &&
              (occ_now < DEPTH || (occ_now > 0 && rx_ready));
      check("pop", 64'(pop), 64'(m_pop));
      check("rx_valid", 64'(rx_valid), 64'(occ_now > 0));
      check("pkt_cnt", 64'(pkt_cnt), 64'(m_pkt));
      check("misroute_cnt", 64'(misroute_cnt), 64'(m_mis));
      check("misroute", 64'(misroute), 64'(m_pulse));
      if (misroute) n_mis_seen++;
      if (occ_now > 0) begin
        check("rx_data", 64'(rx_data), 64'(exp_q[0]));
        if (rx_ready) begin
          void'(exp_q.pop_front());
          m_occ--;
        end
      end
      m_pulse = 1'b0;
      if (m_pop) begin
        n_pops++;
        popped = 1'b1;
        if (is_mine(src_q[0])) begin
          exp_q.push_back(src_q[0]);
          m_occ++;
          m_pkt = m_pkt + 16'd1;
        end else begin
          if (m_mis != 16'hFFFF) m_mis = m_mis + 16'd1;
          m_pulse = 1'b1;
        end
      end
      case (m_mode)
        M_IDLE:   if (enable) m_mode = M_ACTIVE;
        M_ACTIVE: if (!enable) m_mode = M_DRAIN;
        default:  if (enable) m_mode = M_ACTIVE; else if (occ_now == 0) m_mode = M_IDLE;
      endcase
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int s0;
    reset = 1'b0; enable = 1'b0; rx_ready = 1'b0;
    pndng = 1'b0; data_out = '0;
    push(mk(MY_ROW, MY_COL, PL_W'(23'h11)));
    #1;
    check("rst_pop_pending", 64'(pop), 64'd0);
    repeat (2) step();
    reset = 1'b1;
    src_q.delete(); drive_src();
    step();

    // Matching packet: latency 1 to rx_valid, payload intact.
    enable = 1'b1;
    push(mk(MY_ROW, MY_COL, PL_W'(23'h2A)));
    wait_rx_valid("match_timeout", 10);
    check("match_payload", 64'(rx_data[PL_W-1:0]), 64'h2A);
    check("match_pkt_cnt", 64'(pkt_cnt), 64'd1);
    rx_ready = 1'b1; step(); rx_ready = 1'b0;

    // Misrouted packet is popped and dropped.
    s0 = n_mis_seen;
    push(mk(4'd3, 4'd0, PL_W'($urandom)));
    repeat (4) step();
    check("mis_cnt", 64'(misroute_cnt), 64'd1);
    check("mis_rx_valid", 64'(rx_valid), 64'd0);
    check("mis_pulses", 64'(n_mis_seen - s0), 64'd1);

    // Backpressure: 5 pending, only 4 fit.
    p0 = n_pops;
    for (int i = 0; i < 5; i++) push(mk(MY_ROW, MY_COL, PL_W'(32'h100 + i)));
    repeat (8) step();
    check("bp_pops", 64'(n_pops - p0), 64'd4);
    check("bp_pending", 64'(src_q.size()), 64'd1);
    check("bp_pop_full", 64'(pop), 64'd0);
    rx_ready = 1'b1;
    #1;
    check("bp_pop_on_read", 64'(pop), 64'd1);
    step();
    rx_ready = 1'b0;
    check("bp_src_empty", 64'(src_q.size()), 64'd0);
    check("bp_count", 64'(dut.count), 64'd4);
    rx_ready = 1'b1;
    wait_rx_empty("bp_drain_timeout", 12);

    // Drain: disable with 3 buffered; no pops while host empties FIFO.
    rx_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(mk(MY_ROW, MY_COL, PL_W'(32'h200 + i)));
    repeat (5) step();
    enable = 1'b0;
    step();
    push(mk(MY_ROW, MY_COL, PL_W'(23'h333)));
    #1;
    check("drain_pop", 64'(pop), 64'd0);
    rx_ready = 1'b1;
    wait_rx_empty("drain_timeout", 10);
    repeat (2) step();
    check("drain_no_pop", 64'(src_q.size()), 64'd1);
    enable = 1'b1;
    #1;
    check("idle_pop", 64'(pop), 64'd0);
    step();
    check("reenable_pop", 64'(pop), 64'd1);
    repeat (3) step();

    // Saturation of the drop counter.
    enable = 1'b0;
    repeat (3) step();
    force dut.misroute_cnt = 16'hFFFE;
    m_mis = 16'hFFFE;
    step();
    release dut.misroute_cnt;
    s0 = n_mis_seen;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) push(mk(4'd7, 4'd7, PL_W'($urandom)));
    repeat (8) step();
    check("sat_cnt", 64'(misroute_cnt), 64'hFFFF);
    check("sat_pulses", 64'(n_mis_seen - s0), 64'd3);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      enable   = ($urandom_range(0, 7) != 0);
      rx_ready = 1'($urandom);
      if (src_q.size() < 3 && $urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 9) < 6) push(mk(MY_ROW, MY_COL, PL_W'($urandom)));
        else push(mk(4'($urandom), 4'($urandom), PL_W'($urandom)));
      end
      step();
    end

    // Asynchronous reset mid-transfer with a packet pending.
    enable = 1'b1; rx_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(mk(MY_ROW, MY_COL, PL_W'(32'h400 + i)));
    repeat (2) step();
    push(mk(MY_ROW, MY_COL, PL_W'(23'h555)));
    #2;
    reset = 1'b0;
    #1;
    check("async_pop", 64'(pop), 64'd0);
    check("async_rx_valid", 64'(rx_valid), 64'd0);
    check("async_rx_data", 64'(rx_data), 64'd0);
    check("async_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check("async_mis_cnt", 64'(misroute_cnt), 64'd0);
    repeat (2) step();
    reset = 1'b1;
    #1;
    check("rel_pop0", 64'(pop), 64'd0);
    step();
    check("rel_pop1", 64'(pop), 64'd1);
    rx_ready = 1'b1;
    repeat (12) step();
    check("final_src_empty", 64'(src_q.size()), 64'd0);
    check("final_exp_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
